if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit: PC, IR and IM read sequencing FSM
// Optional feature macro: IF_FETCH_ALIGN_CHECK_EN (reject misaligned redirects, raise align_err)
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  output logic [31:0] im_addr,
  output logic        im_r,
  output logic        im_w,
  output logic [31:0] im_wd,
  input  logic [31:0] im_rd,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ir_valid,
  output logic        busy,
  output logic        align_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_CAPT = 2'd3
  } state_t;

  // WAIT is only entered when RD_LAT > 1, so clamp the load value for RD_LAT == 1
  localparam int         CNT_INIT_I = (RD_LAT > 1) ? (RD_LAT - 2) : 0;
  localparam logic [1:0] CNT_INIT   = 2'(CNT_INIT_I);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic        r_pending;
  logic [1:0]  r_cnt;
  logic        w_pending_nxt;
  logic [1:0]  w_cnt_nxt;
  logic        w_im_r;
  logic        w_capture;
  logic        w_redir;
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef IF_FETCH_ALIGN_CHECK_EN
  logic w_misalign;
  logic r_align_err;

  // A misaligned redirect is dropped entirely; it neither moves the PC nor aborts a fetch
  assign w_misalign = pc_we & (pc_next[1:0] != 2'b00);
  assign w_redir    = pc_we & ~w_misalign;
  assign w_redir_pc = pc_next;

  // Sticky alignment error, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_align_err <= 1'b0;
    end else if (w_misalign) begin
      r_align_err <= 1'b1;
    end
  end

  assign align_err = r_align_err;
`else
  // Without checking, the low address bits are simply cleared on load
  assign w_redir    = pc_we;
  assign w_redir_pc = pc_next & 32'hFFFF_FFFC;
  assign align_err  = 1'b0;
`endif

  // Next-state, IM read enable, wait counter and pending-start decode
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_cnt_nxt     = r_cnt;
    w_im_r        = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_redir) begin
          // redirect wins this cycle; a coincident start fetches from the new PC next cycle
          w_pending_nxt = r_pending | start;
        end else if (start || r_pending) begin
          w_state_nxt   = S_REQ;
          w_pending_nxt = 1'b0;
        end
      end
      S_REQ: begin
        w_im_r = 1'b1;
        if (w_redir) begin
          w_state_nxt = S_IDLE;
        end else if (RD_LAT == 1) begin
          w_state_nxt = S_CAPT;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        w_im_r = 1'b1;
        if (w_redir) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 2'd0) begin
          w_state_nxt = S_CAPT;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      S_CAPT: begin
        w_im_r      = 1'b1;
        w_state_nxt = S_IDLE;
        w_capture   = ~w_redir;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC, IR and valid-pulse registers; a redirect overrides the pc+4 increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= 32'd0;
      r_ir_valid <= 1'b0;
      r_pending  <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ir_valid <= w_capture;
      if (w_capture) begin
        r_ir <= im_rd;
      end
      if (w_redir) begin
        r_pc <= w_redir_pc;
      end else if (w_capture) begin
        r_pc <= w_pc_plus4;
      end
    end
  end

  assign im_addr  = r_pc;
  assign im_r     = w_im_r;
  assign im_w     = 1'b0;
  assign im_wd    = 32'd0;
  assign ir       = r_ir;
  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign ir_valid = r_ir_valid;
  assign busy     = (r_state != S_IDLE);

endmodule
